// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences the AES key-expansion unit and serves stored round keys
module aes_key_sched_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RK = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         exp_start,
  output logic [255:0] exp_key,
  output logic [1:0]   exp_len,
  input  logic [127:0] exp_subkey,
  input  logic         exp_rdy,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  input  logic         rk_rev,
  output logic [127:0] rk_rd_data,
  output logic         rk_rd_valid,
  output logic         keys_ready,
  output logic [3:0]   num_rounds,
  output logic         err
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, COLLECT, DONE} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wdog;
  logic [3:0] cnt, target, rd_idx;
  logic [127:0] store [MAX_RK];
  logic accept, bad_len, last_wr, timeout, rd_ok;
  assign key_ready = state == IDLE || state == DONE;
  assign exp_start = state == START;
  assign accept = key_valid && key_ready;
  assign bad_len = key_len == 2'b11;
  assign last_wr = state == COLLECT && exp_rdy && cnt == target - 4'd1;
  assign timeout = state == COLLECT && !exp_rdy && wdog == WW'(TIMEOUT_CYCLES - 1);
  assign rd_idx = rk_rev ? num_rounds - rk_rd_idx : rk_rd_idx;
  assign rd_ok = rk_rd_en && keys_ready;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: accept only happens in IDLE/DONE, so it takes priority
  always_comb begin
    state_nx = state;
    state_nx = accept ? (bad_len ? IDLE : START) :
               state == START ? COLLECT :
               last_wr ? DONE :
               timeout ? IDLE : state;
  end
  // key latch, collection counters, status flags and registered read port
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      exp_key <= '0;
      exp_len <= '0;
      target <= '0;
      cnt <= '0;
      wdog <= '0;
      keys_ready <= 1'b0;
      num_rounds <= '0;
      err <= 1'b0;
      rk_rd_valid <= 1'b0;
      rk_rd_data <= '0;
    end else begin
      if (accept && bad_len) begin
        err <= 1'b1;
        keys_ready <= 1'b0;
      end else if (accept) begin
        exp_key <= key_in;
        exp_len <= key_len;
        target <= key_len == 2'b00 ? 4'd11 : key_len == 2'b01 ? 4'd13 : 4'd15;
        keys_ready <= 1'b0;
        err <= 1'b0;
      end
      cnt <= state == START ? '0 : (state == COLLECT && exp_rdy) ? cnt + 4'd1 : cnt;
      wdog <= (state == START || exp_rdy) ? '0 : state == COLLECT ? wdog + 1'b1 : wdog;
      if (last_wr) begin
        keys_ready <= 1'b1;
        num_rounds <= target - 4'd1;
      end
      if (timeout) begin
        err <= 1'b1;
        keys_ready <= 1'b0;
      end
      rk_rd_valid <= rd_ok;
      if (rd_ok) rk_rd_data <= rk_rd_idx > num_rounds ? '0 : store[rd_idx];
    end
  // round-key store, written only while collecting
  always_ff @(posedge clk)
    if (state == COLLECT && exp_rdy) store[cnt] <= exp_subkey;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed self-checking bench for the key schedule controller
module tb_aes_key_sched_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [255:0] key_in = '0, exp_key;
  logic [1:0] key_len = '0, exp_len;
  logic key_valid = 1'b0, key_ready, exp_start;
  logic [127:0] exp_subkey = '0, rk_rd_data;
  logic exp_rdy = 1'b0, rk_rd_en = 1'b0, rk_rev = 1'b0, rk_rd_valid, keys_ready, err;
  logic [3:0] rk_rd_idx = '0, num_rounds;
  logic [127:0] rk [15];
  int checks = 0, errors = 0, starts = 0, st;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  aes_key_sched_ctrl dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_len(key_len), .key_valid(key_valid),
    .key_ready(key_ready), .exp_start(exp_start), .exp_key(exp_key), .exp_len(exp_len),
    .exp_subkey(exp_subkey), .exp_rdy(exp_rdy), .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
    .rk_rev(rk_rev), .rk_rd_data(rk_rd_data), .rk_rd_valid(rk_rd_valid),
    .keys_ready(keys_ready), .num_rounds(num_rounds), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (exp_start) starts <= starts + 1;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [255:0] k, input logic [1:0] l);
    key_in = k;
    key_len = l;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask
  task automatic stream(input int lo, input int hi, input int gap, input bit hold);
    for (int i = lo; i < hi; i++) begin
      key_valid = hold && i < hi - 1;
      exp_subkey = rk[i];
      exp_rdy = 1'b1;
      tick();
      exp_rdy = 1'b0;
      if (i < hi - 1) repeat (gap) tick();
    end
    key_valid = 1'b0;
  endtask
  task automatic rd(input logic [3:0] idx, input bit rev);
    rk_rd_idx = idx;
    rk_rev = rev;
    rk_rd_en = 1'b1;
    tick();
    rk_rd_en = 1'b0;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_ctrl"}, {key_ready, exp_start, exp_len, rk_rd_valid, keys_ready, num_rounds, err},
        {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0});
    chk({tag, "_key"}, exp_key, '0);
    chk({tag, "_data"}, rk_rd_data, '0);
  endtask
  initial begin
    tick();
    tick();
    reset_vals("rst");
    reset = 1'b0;
    tick();
    rk[0] = K128[255:128];
    rk[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2] = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3] = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4] = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6] = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8] = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9] = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    load(K128, 2'b00);
    chk("a128_start", {exp_start, key_ready}, 2'b10);
    chk("a128_key", exp_key, K128);
    chk("a128_len", exp_len, 2'b00);
    tick();
    chk("a128_pulse", exp_start, 1'b0);
    stream(0, 10, 0, 0);
    chk("a128_not_yet", keys_ready, 1'b0);
    stream(10, 11, 0, 0);
    chk("a128_done", {keys_ready, key_ready, num_rounds}, {1'b1, 1'b1, 4'd10});
    chk("a128_starts", starts, 1);
    rd(4'd10, 1'b0);
    chk("a128_rd10", {rk_rd_valid, rk_rd_data}, {1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    rd(4'd0, 1'b1);
    chk("a128_rev0", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd3, 1'b1);
    chk("a128_rev3", rk_rd_data, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    rd(4'd12, 1'b0);
    chk("a128_oob", {rk_rd_valid, rk_rd_data}, {1'b1, 128'h0});
    rk_rd_idx = 4'd10;
    rk_rev = 1'b0;
    rk_rd_en = 1'b1;
    load(K192, 2'b01);
    rk_rd_en = 1'b0;
    chk("same_cycle_rd", {rk_rd_valid, rk_rd_data}, {1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    chk("same_cycle_kr", {keys_ready, exp_start}, 2'b01);
    for (int i = 0; i < 15; i++) rk[i] = {4{32'h19200000 | i}};
    rk[0] = 128'h8e73b0f7da0e6452c810f32b809079e5;
    rk[12] = 128'he98ba06f448c773c8ecc720401002202;
    tick();
    stream(0, 13, 0, 1);
    chk("a192_starts", starts, 2);
    chk("a192_done", {keys_ready, num_rounds}, {1'b1, 4'd12});
    rd(4'd0, 1'b1);
    chk("a192_rev0", rk_rd_data, 128'he98ba06f448c773c8ecc720401002202);
    rd(4'd0, 1'b0);
    chk("a192_fwd0", rk_rd_data, 128'h8e73b0f7da0e6452c810f32b809079e5);
    rd(4'd5, 1'b1);
    chk("a192_rev5", rk_rd_data, {4{32'h19200007}});
    rd(4'd13, 1'b0);
    chk("a192_oob", {rk_rd_valid, rk_rd_data}, {1'b1, 128'h0});
    for (int i = 0; i < 15; i++) rk[i] = {4{32'h25600000 | i}};
    rk[0] = K256[255:128];
    load(K256, 2'b10);
    tick();
    stream(0, 15, 5, 0);
    chk("a256_done", {keys_ready, num_rounds}, {1'b1, 4'd14});
    rd(4'd14, 1'b0);
    chk("a256_rd14", rk_rd_data, {4{32'h2560000e}});
    rd(4'd0, 1'b1);
    chk("a256_rev0", rk_rd_data, {4{32'h2560000e}});
    rd(4'd9, 1'b0);
    chk("a256_rd9", rk_rd_data, {4{32'h25600009}});
    load(K256, 2'b10);
    tick();
    stream(0, 3, 0, 0);
    repeat (63) tick();
    chk("wdog_63", {err, key_ready}, 2'b00);
    tick();
    chk("wdog_64", {err, keys_ready, key_ready}, 3'b101);
    rd(4'd0, 1'b0);
    chk("rd_not_ready", {rk_rd_valid, rk_rd_data}, {1'b0, {4{32'h25600009}}});
    for (int i = 0; i < 11; i++) rk[i] = {4{32'h12800000 | i}};
    load(K128, 2'b00);
    chk("load_clr_err", {err, exp_start}, 2'b01);
    tick();
    stream(0, 11, 0, 0);
    st = starts;
    load(K256, 2'b11);
    chk("bad_len", {err, keys_ready, key_ready, exp_start}, 4'b1010);
    tick();
    chk("bad_len_nostart", starts, st);
    load(K128, 2'b00);
    chk("bad_len_clr", {err, exp_start}, 2'b01);
    tick();
    stream(0, 4, 0, 0);
    exp_subkey = rk[4];
    exp_rdy = 1'b1;
    reset = 1'b1;
    #1;
    reset_vals("rst_async");
    tick();
    exp_rdy = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_no_ready", {keys_ready, key_ready, num_rounds}, {1'b0, 1'b1, 4'd0});
    rd(4'd0, 1'b0);
    chk("rst_rd", rk_rd_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
